// File: rtl/nabu_cpu_pkg.sv
// Shared Z80/Nabu CPU constants and the fetch-decoder state type.
package nabu_cpu_pkg;

  localparam logic [7:0] OP_CB     = 8'hCB;
  localparam logic [7:0] OP_DD     = 8'hDD;
  localparam logic [7:0] OP_ED     = 8'hED;
  localparam logic [7:0] OP_FD     = 8'hFD;
  localparam logic [7:0] OP_EI     = 8'hFB;
  localparam logic [7:0] OP_JP     = 8'hC3;
  localparam logic [7:0] OP_RETN_2 = 8'h45;

  typedef enum logic [1:0] {
    BASE   = 2'd0,
    PREFIX = 2'd1,
    IDX    = 2'd2
  } dec_state_e;

  function automatic logic is_idx_prefix(input logic [7:0] op);
    return (op == OP_DD) || (op == OP_FD);
  endfunction

endpackage

// File: rtl/isr_fetch_decoder_if.sv
// Trap-control bundle: raw Z80 bus pins in, instruction-boundary qualifiers out.
interface isr_fetch_decoder_if;

  logic       m1_n;
  logic       mreq_n;
  logic       rd_n;
  logic       iorq_n;
  logic [7:0] data;
  logic       trap_state;
  logic       new_isr;
  logic       last_isr_jmp;
  logic [7:0] last_opcode;

  modport master (
    input  m1_n, mreq_n, rd_n, iorq_n, data, trap_state,
    output new_isr, last_isr_jmp, last_opcode
  );

  modport slave (
    output m1_n, mreq_n, rd_n, iorq_n, data, trap_state,
    input  new_isr, last_isr_jmp, last_opcode
  );

endinterface

// File: rtl/isr_fetch_decoder_bus_sync.sv
// N-stage synchronizer (STAGES >= 2) for one raw bus strobe, async active-low reset.
module bus_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/isr_fetch_decoder.sv
// Z80 opcode-fetch watcher producing new_isr / last_isr_jmp for the trap logic.
// Optional: define ISR_RETN_EXIT_EN to let ED-45 (RETN) under trap also flag last_isr_jmp.
module isr_fetch_decoder
  import nabu_cpu_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] JMP_OPCODE  = 8'hC3
) (
  input logic                 clk,
  input logic                 rst_n,
  isr_fetch_decoder_if.master bus
);

  logic m1_s, mreq_s, rd_s, iorq_s;

  // Syncs reset to asserted so nothing is trusted until m1_n is seen high.
  bus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_m1 (
    .clk(clk), .rst_n(rst_n), .d_i(bus.m1_n), .q_o(m1_s));
  bus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mreq (
    .clk(clk), .rst_n(rst_n), .d_i(bus.mreq_n), .q_o(mreq_s));
  bus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_rd (
    .clk(clk), .rst_n(rst_n), .d_i(bus.rd_n), .q_o(rd_s));
  bus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_iorq (
    .clk(clk), .rst_n(rst_n), .d_i(bus.iorq_n), .q_o(iorq_s));

  dec_state_e state_q;
  logic       armed_q;
  logic       fetch_q;
  logic [7:0] shadow_q;
  logic       new_isr_q;
  logic       last_isr_jmp_q;
  logic [7:0] last_opcode_q;
`ifdef ISR_RETN_EXIT_EN
  logic       prefix_ed_q;
`endif

  logic fetch_det;
  logic fetch_end;
  logic inta_det;
  logic jp_hit;

  assign fetch_det = ~m1_s & ~mreq_s & ~rd_s;
  assign fetch_end = fetch_q & ~fetch_det & armed_q;
  assign inta_det  = armed_q & ~m1_s & ~iorq_s;
  assign jp_hit    = (shadow_q == JMP_OPCODE) & bus.trap_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= BASE;
      armed_q        <= 1'b0;
      fetch_q        <= 1'b0;
      shadow_q       <= 8'h00;
      new_isr_q      <= 1'b1;
      last_isr_jmp_q <= 1'b0;
      last_opcode_q  <= 8'h00;
`ifdef ISR_RETN_EXIT_EN
      prefix_ed_q    <= 1'b0;
`endif
    end else begin
      fetch_q <= fetch_det;
      if (fetch_det) shadow_q <= bus.data;
      if (m1_s)      armed_q  <= 1'b1;

      if (fetch_end) begin
        last_opcode_q  <= shadow_q;
        last_isr_jmp_q <= 1'b0;
`ifdef ISR_RETN_EXIT_EN
        prefix_ed_q    <= (shadow_q == OP_ED);
`endif
        case (state_q)
          BASE: begin
            last_isr_jmp_q <= jp_hit;
            if (shadow_q == OP_CB || shadow_q == OP_ED) begin
              state_q   <= PREFIX;
              new_isr_q <= 1'b0;
            end else if (is_idx_prefix(shadow_q)) begin
              state_q   <= IDX;
              new_isr_q <= 1'b0;
            end else begin
              state_q   <= BASE;
              new_isr_q <= (shadow_q != OP_EI);
            end
          end
          PREFIX: begin
            state_q   <= BASE;
            new_isr_q <= 1'b1;
`ifdef ISR_RETN_EXIT_EN
            last_isr_jmp_q <= prefix_ed_q & (shadow_q == OP_RETN_2) & bus.trap_state;
`endif
          end
          IDX: begin
            // DD/FD CB: displacement and operation follow as non-M1 reads
            if (is_idx_prefix(shadow_q)) begin
              state_q   <= IDX;
              new_isr_q <= 1'b0;
            end else if (shadow_q == OP_ED) begin
              state_q   <= PREFIX;
              new_isr_q <= 1'b0;
            end else begin
              state_q   <= BASE;
              new_isr_q <= 1'b1;
            end
          end
          default: begin
            state_q   <= BASE;
            new_isr_q <= 1'b1;
          end
        endcase
      end else if (inta_det) begin
        state_q        <= BASE;
        last_isr_jmp_q <= 1'b0;
      end
    end
  end

  assign bus.new_isr      = new_isr_q;
  assign bus.last_isr_jmp = last_isr_jmp_q;
  assign bus.last_opcode  = last_opcode_q;

endmodule

// File: tb/tb_isr_fetch_decoder.sv
// Self-checking bench for isr_fetch_decoder: vector table, corner sequences, random vs. model.
module tb_isr_fetch_decoder;

  localparam int SYNC = 2;
`ifdef ISR_RETN_EXIT_EN
  localparam bit RETN_EN = 1'b1;
`else
  localparam bit RETN_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  isr_fetch_decoder_if bif();

  isr_fetch_decoder #(.SYNC_STAGES(SYNC), .JMP_OPCODE(8'hC3)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: bytes of the instruction still being assembled.
  logic [7:0] pend[$];
  bit         m_new;
  bit         m_jmp;
  logic [7:0] m_op;

  typedef struct {
    logic [7:0] op;
    bit         trap;
    int         nrd;
    bit         exp_new;
    bit         exp_jmp;
  } vec_t;

  vec_t vt[25];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    pend.delete();
    m_new = 1'b1;
    m_jmp = 1'b0;
    m_op  = 8'h00;
  endtask

  task automatic model_decode(input logic [7:0] op, input bit trap);
    bit         was_empty;
    logic [7:0] last;
    was_empty = (pend.size() == 0);
    last      = was_empty ? 8'h00 : pend[pend.size()-1];
    m_op  = op;
    m_jmp = 1'b0;
    if (was_empty) begin
      m_jmp = (op == 8'hC3) && trap;
      if (op inside {8'hCB, 8'hED, 8'hDD, 8'hFD}) pend.push_back(op);
    end else if (last == 8'hCB) begin
      pend.delete();
    end else if (last == 8'hED) begin
      if (RETN_EN) m_jmp = (op == 8'h45) && trap;
      pend.delete();
    end else begin
      if (op inside {8'hDD, 8'hFD, 8'hED}) pend.push_back(op);
      else pend.delete();
    end
    m_new = (pend.size() == 0) && !(was_empty && op == 8'hFB);
  endtask

  task automatic check(input string name, input bit en, input bit ej, input logic [7:0] eo);
    n_cmp++;
    if (bif.new_isr !== en) begin
      n_bad++;
      $display("FAIL %s new_isr got %b want %b", name, bif.new_isr, en);
    end
    n_cmp++;
    if (bif.last_isr_jmp !== ej) begin
      n_bad++;
      $display("FAIL %s last_isr_jmp got %b want %b", name, bif.last_isr_jmp, ej);
    end
    n_cmp++;
    if (bif.last_opcode !== eo) begin
      n_bad++;
      $display("FAIL %s last_opcode got %02h want %02h", name, bif.last_opcode, eo);
    end
  endtask

  task automatic do_reset();
    bif.m1_n = 1'b1; bif.mreq_n = 1'b1; bif.rd_n = 1'b1; bif.iorq_n = 1'b1;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(SYNC + 3);
    model_reset();
  endtask

  task automatic fetch(input logic [7:0] op, input bit trap);
    bif.trap_state = trap;
    bif.data   = op;
    bif.m1_n   = 1'b0; bif.mreq_n = 1'b0; bif.rd_n = 1'b0;
    tick(4);
    bif.m1_n   = 1'b1; bif.mreq_n = 1'b1; bif.rd_n = 1'b1;
    tick(SYNC + 1);
    bif.data   = 8'($urandom);
    tick(2);
    model_decode(op, trap);
  endtask

  task automatic mem_read(input logic [7:0] d);
    bif.data   = d;
    bif.mreq_n = 1'b0; bif.rd_n = 1'b0;
    tick(3);
    bif.mreq_n = 1'b1; bif.rd_n = 1'b1;
    tick(SYNC + 1);
    bif.data   = 8'($urandom);
    tick(1);
  endtask

  task automatic inta();
    bif.data   = 8'($urandom);
    bif.m1_n   = 1'b0; bif.iorq_n = 1'b0;
    tick(3);
    bif.m1_n   = 1'b1; bif.iorq_n = 1'b1;
    tick(SYNC + 3);
    pend.delete();
    m_jmp = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pool[9];
    int         r;
    logic [7:0] op;
    bit         tr;

    bif.m1_n = 1'b1; bif.mreq_n = 1'b1; bif.rd_n = 1'b1; bif.iorq_n = 1'b1;
    bif.data = 8'h00; bif.trap_state = 1'b0;
    rst_n = 1'b0;

    vt[0]  = '{8'h00, 1'b0, 0, 1'b1, 1'b0};
    vt[1]  = '{8'hDD, 1'b0, 0, 1'b0, 1'b0};
    vt[2]  = '{8'h21, 1'b0, 0, 1'b1, 1'b0};
    vt[3]  = '{8'hC3, 1'b1, 2, 1'b1, 1'b1};
    vt[4]  = '{8'h00, 1'b1, 0, 1'b1, 1'b0};
    vt[5]  = '{8'hC3, 1'b0, 2, 1'b1, 1'b0};
    vt[6]  = '{8'hFB, 1'b0, 0, 1'b0, 1'b0};
    vt[7]  = '{8'h00, 1'b0, 0, 1'b1, 1'b0};
    vt[8]  = '{8'hED, 1'b1, 0, 1'b0, 1'b0};
    vt[9]  = '{8'h45, 1'b1, 0, 1'b1, RETN_EN};
    vt[10] = '{8'hCB, 1'b1, 0, 1'b0, 1'b0};
    vt[11] = '{8'h45, 1'b1, 0, 1'b1, 1'b0};
    vt[12] = '{8'hFD, 1'b0, 0, 1'b0, 1'b0};
    vt[13] = '{8'hDD, 1'b0, 0, 1'b0, 1'b0};
    vt[14] = '{8'hED, 1'b1, 0, 1'b0, 1'b0};
    vt[15] = '{8'h45, 1'b1, 0, 1'b1, RETN_EN};
    vt[16] = '{8'hDD, 1'b0, 0, 1'b0, 1'b0};
    vt[17] = '{8'hCB, 1'b0, 2, 1'b1, 1'b0};
    vt[18] = '{8'hC3, 1'b1, 0, 1'b1, 1'b1};
    vt[19] = '{8'hFB, 1'b1, 0, 1'b0, 1'b0};
    vt[20] = '{8'hFB, 1'b0, 0, 1'b0, 1'b0};
    vt[21] = '{8'hCB, 1'b1, 0, 1'b0, 1'b0};
    vt[22] = '{8'hC3, 1'b1, 0, 1'b1, 1'b0};
    vt[23] = '{8'hDD, 1'b1, 0, 1'b0, 1'b0};
    vt[24] = '{8'hC3, 1'b1, 0, 1'b1, 1'b0};

    tick(3);
    check("reset_hold", 1'b1, 1'b0, 8'h00);
    rst_n = 1'b1;
    tick(SYNC + 3);
    model_reset();
    check("reset_release", 1'b1, 1'b0, 8'h00);

    foreach (vt[i]) begin
      fetch(vt[i].op, vt[i].trap);
      for (int k = 0; k < vt[i].nrd; k++) mem_read(8'($urandom));
      check($sformatf("vec%0d", i), vt[i].exp_new, vt[i].exp_jmp, vt[i].op);
    end

    // Exact latency: outputs move SYNC_STAGES+1 clocks after the strobes rise.
    bif.trap_state = 1'b0;
    bif.data = 8'h3E;
    bif.m1_n = 1'b0; bif.mreq_n = 1'b0; bif.rd_n = 1'b0;
    tick(4);
    bif.m1_n = 1'b1; bif.mreq_n = 1'b1; bif.rd_n = 1'b1;
    repeat (SYNC) @(posedge clk);
    #1;
    check("latency_early", 1'b1, 1'b0, 8'hC3);
    @(posedge clk);
    #1;
    check("latency_exact", 1'b1, 1'b0, 8'h3E);
    tick(3);

    // INTA clears the jump flag, holds new_isr and forces BASE.
    fetch(8'hC3, 1'b1);
    check("inta_pre_jp", 1'b1, 1'b1, 8'hC3);
    inta();
    check("inta_clr_jmp", 1'b1, 1'b0, 8'hC3);
    fetch(8'hDD, 1'b0);
    inta();
    check("inta_hold_new", 1'b0, 1'b0, 8'hDD);
    fetch(8'hCB, 1'b0);
    check("inta_base_cb", 1'b0, 1'b0, 8'hCB);
    fetch(8'h00, 1'b0);
    check("inta_after", 1'b1, 1'b0, 8'h00);

    // Reset in the middle of an ED fetch, released while m1_n is still low.
    fetch(8'hDD, 1'b0);
    bif.trap_state = 1'b1;
    bif.data = 8'hED;
    bif.m1_n = 1'b0; bif.mreq_n = 1'b0; bif.rd_n = 1'b0;
    tick(3);
    rst_n = 1'b0;
    tick(2);
    check("midfetch_in_reset", 1'b1, 1'b0, 8'h00);
    rst_n = 1'b1;
    tick(3);
    bif.m1_n = 1'b1; bif.mreq_n = 1'b1; bif.rd_n = 1'b1;
    tick(SYNC + 3);
    check("midfetch_ignored", 1'b1, 1'b0, 8'h00);
    fetch(8'h45, 1'b1);
    check("midfetch_45_base", 1'b1, 1'b0, 8'h45);
    fetch(8'hED, 1'b1);
    fetch(8'h45, 1'b1);
    check("retn_exit", 1'b1, RETN_EN, 8'h45);

    // Random stream against the model.
    do_reset();
    pool[0] = 8'hCB; pool[1] = 8'hDD; pool[2] = 8'hED; pool[3] = 8'hFD;
    pool[4] = 8'hFB; pool[5] = 8'hC3; pool[6] = 8'h45; pool[7] = 8'h00;
    pool[8] = 8'h00;
    for (int n = 0; n < 250; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        mem_read(8'($urandom));
      end else if (r == 1) begin
        inta();
      end else begin
        pool[8] = 8'($urandom);
        op = pool[$urandom_range(0, 8)];
        tr = bit'($urandom_range(0, 1));
        fetch(op, tr);
      end
      check($sformatf("rand%0d", n), m_new, m_jmp, m_op);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
